// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// MULT/MULTU use a WIDTH-iteration shift/add datapath and DIV/DIVU use a
// WIDTH-iteration restoring-subtract datapath. Both work on operand magnitudes
// and apply a two's-complement sign fix in a final cycle before HI/LO are
// written. MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   op1       rs operand: multiplicand / dividend / MTHI-MTLO source
//   op2       rt operand: multiplier / divisor
//   Mul       start multiply (wins over Div when both are high)
//   Div       start divide
//   Unsigned  1 = MULTU/DIVU, 0 = signed
//   WriteHi   MTHI: hi <= op1 (idle only)
//   WriteLo   MTLO: lo <= op1 (idle only)
//   ReadHi    MFHI request, only feeds the stall
//   ReadLo    MFLO request, only feeds the stall
//   hi, lo    HI/LO registers
//   busy      operation in flight
//   done      one-cycle pulse after HI/LO are written by an operation
//   stall     busy while the pipeline presents any HI/LO related request
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             Mul,
    input  logic             Div,
    input  logic             Unsigned,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic             ReadHi,
    input  logic             ReadLo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [CNT_W-1:0]   r_count;
    logic               r_isDiv;
    logic               r_negRes;
    logic               r_negRem;
    logic               r_divZero;
    logic [WIDTH-1:0]   r_origA;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_start;
    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_divShift;
    logic               w_divOk;
    logic [WIDTH-1:0]   w_divSub;
    logic [WIDTH-1:0]   w_divRem;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodNeg;

    // A start is only recognised in IDLE; anything presented while busy is
    // ignored and has to be held by the pipeline through the stall.
    assign w_start = (r_state == IDLE) && (Mul || Div);

    // Signed operands are reduced to magnitudes up front. The most negative
    // value negates to itself, which is exactly its unsigned magnitude.
    assign w_negA = ~Unsigned & op1[WIDTH-1];
    assign w_negB = ~Unsigned & op2[WIDTH-1];
    assign w_magA = w_negA ? ('0 - op1) : op1;
    assign w_magB = w_negB ? ('0 - op2) : op2;

    // Shift/add multiply step: {r_acc, r_q} is the partial product with the
    // multiplier draining out of the bottom of r_q. The carry out of the add
    // lands in the top of the accumulator after the right shift.
    assign w_mulSum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);

    // Restoring divide step: the partial remainder picks up the next dividend
    // bit from the top of r_q. Since the remainder is always below the
    // divisor, the subtraction result fits WIDTH bits when it succeeds.
    assign w_divShift = {r_acc, r_q[WIDTH-1]};
    assign w_divOk    = (w_divShift >= {1'b0, r_opnd});
    assign w_divSub   = w_divShift[WIDTH-1:0] - r_opnd;
    assign w_divRem   = w_divOk ? w_divSub : w_divShift[WIDTH-1:0];

    assign w_prod    = {r_acc, r_q};
    assign w_prodNeg = '0 - w_prod;

    // State register for the IDLE -> CALC -> FIN sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: CALC runs exactly WIDTH iterations, FIN lasts one cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (r_count == LAST_ITER) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath and HI/LO. Operands and result signs are captured at the start
    // so later operand or Unsigned changes cannot disturb the operation.
    // HI/LO only change in FIN or through idle MTHI/MTLO, so no partial
    // result is ever visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_origA   <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_isDiv   <= ~Mul;
                        r_negRes  <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                        r_divZero <= ~Mul && (op2 == '0);
                        r_origA   <= op1;
                        r_acc     <= '0;
                        r_count   <= '0;
                        if (Mul) begin
                            r_q    <= w_magB;
                            r_opnd <= w_magA;
                        end else begin
                            r_q    <= w_magA;
                            r_opnd <= w_magB;
                        end
                    end else begin
                        if (WriteHi) begin
                            r_hi <= op1;
                        end
                        if (WriteLo) begin
                            r_lo <= op1;
                        end
                    end
                end
                CALC: begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_isDiv) begin
                        r_acc <= w_divRem;
                        r_q   <= {r_q[WIDTH-2:0], w_divOk};
                    end else begin
                        r_acc <= w_mulSum[WIDTH:1];
                        r_q   <= {w_mulSum[0], r_q[WIDTH-1:1]};
                    end
                end
                FIN: begin
                    r_done <= 1'b1;
                    if (r_isDiv && r_divZero) begin
                        // Divide by zero returns an all-ones quotient and the
                        // untouched dividend as remainder.
                        r_lo <= '1;
                        r_hi <= r_origA;
                    end else if (r_isDiv) begin
                        r_lo <= r_negRes ? ('0 - r_q)   : r_q;
                        r_hi <= r_negRem ? ('0 - r_acc) : r_acc;
                    end else begin
                        {r_hi, r_lo} <= r_negRes ? w_prodNeg : w_prod;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    assign busy  = (r_state != IDLE);
    assign stall = busy & (ReadHi | ReadLo | Mul | Div | WriteHi | WriteLo);

endmodule

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit
// ----------------------------------------------------------------------------
// Directed bench for muldiv_unit. Each started operation pushes its
// hand-computed HI/LO into a queue; a monitor pops and compares whenever the
// DUT pulses done. Busy length, stall, MTHI/MTLO and reset are checked inline.
// ============================================================================
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          id;
    } expect_t;

    logic        clk;
    logic        reset;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        Mul;
    logic        Div;
    logic        Unsigned;
    logic        WriteHi;
    logic        WriteLo;
    logic        ReadHi;
    logic        ReadLo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    expect_t     sbQueue[$];
    int          checks = 0;
    int          errors = 0;
    int          opId = 0;
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .op1      (op1),
        .op2      (op2),
        .Mul      (Mul),
        .Div      (Div),
        .Unsigned (Unsigned),
        .WriteHi  (WriteHi),
        .WriteLo  (WriteLo),
        .ReadHi   (ReadHi),
        .ReadLo   (ReadLo),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic compare used by both the stimulus and the monitor.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone actual=1 expected=0");
            end else begin
                expect_t e;
                e = sbQueue.pop_front();
                checkOutput($sformatf("op%0d_hi", e.id), hi, e.expHi);
                checkOutput($sformatf("op%0d_lo", e.id), lo, e.expLo);
            end
        end
    end

    // Issue one Mul/Div from a negedge, scramble the inputs after acceptance,
    // and return on the negedge where done is visible (next op may start there).
    task automatic applyStimulus(input logic m, input logic d, input logic u,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eHi, input logic [31:0] eLo,
                                 input bit checkDrop);
        int cnt;
        opId++;
        sbQueue.push_back('{expHi: eHi, expLo: eLo, id: opId});
        modelHi = eHi;
        modelLo = eLo;
        Mul = m;
        Div = d;
        Unsigned = u;
        op1 = a;
        op2 = b;
        @(negedge clk);
        Mul = 1'b0;
        Div = 1'b0;
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        Unsigned = ~u;
        op1 = ~a;
        op2 = 32'h3;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput($sformatf("op%0d_busyLen", opId), cnt, 32'd33);
        if (checkDrop) begin
            @(negedge clk);
            checkOutput($sformatf("op%0d_doneDrop", opId), {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        op1 = '0;
        op2 = '0;
        Mul = 1'b0;
        Div = 1'b0;
        Unsigned = 1'b0;
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        ReadHi = 1'b0;
        ReadLo = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("idle_stall", {31'd0, stall}, 32'd0);
        ReadLo = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Multiplies, including back-to-back acceptance on the done cycle.
        applyStimulus(1, 0, 0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        applyStimulus(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        applyStimulus(1, 0, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);

        // Divides: signs, unsigned, divide by zero, most-negative by -1.
        applyStimulus(0, 1, 0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        applyStimulus(0, 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0);
        applyStimulus(0, 1, 0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        applyStimulus(0, 1, 1, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0);
        applyStimulus(0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b1);

        // MTHI and MTLO together in idle.
        WriteHi = 1'b1;
        WriteLo = 1'b1;
        op1 = 32'h00005A5A;
        @(negedge clk);
        WriteHi = 1'b0;
        WriteLo = 1'b0;
        checkOutput("mthi_hi", hi, 32'h00005A5A);
        checkOutput("mtlo_lo", lo, 32'h00005A5A);

        // A start coincident with MTHI/MTLO wins; the writes are dropped.
        WriteHi = 1'b1;
        WriteLo = 1'b1;
        applyStimulus(1, 0, 1, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b1);

        // Requests while busy: stall asserted, writes and new Mul ignored.
        opId++;
        sbQueue.push_back('{expHi: 32'h0, expLo: 32'h0000000F, id: opId});
        Mul = 1'b1;
        Unsigned = 1'b0;
        op1 = 32'h3;
        op2 = 32'h5;
        @(negedge clk);
        Mul = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt >= 5 && cnt <= 7) begin
                ReadLo = 1'b1;
                WriteHi = 1'b1;
                Mul = 1'b1;
                op1 = 32'h0000AAAA;
                #1;
                checkOutput($sformatf("busyStall_c%0d", cnt), {31'd0, stall}, 32'd1);
                checkOutput($sformatf("busyHoldHi_c%0d", cnt), hi, modelHi);
                checkOutput($sformatf("busyHoldLo_c%0d", cnt), lo, modelLo);
            end else begin
                ReadLo = 1'b0;
                WriteHi = 1'b0;
                Mul = 1'b0;
            end
            @(negedge clk);
        end
        ReadLo = 1'b0;
        WriteHi = 1'b0;
        Mul = 1'b0;
        checkOutput("busyTest_busyLen", cnt, 32'd33);
        @(negedge clk);
        checkOutput("noSecondMul_busy", {31'd0, busy}, 32'd0);
        modelHi = 32'h0;
        modelLo = 32'h0000000F;

        // Asynchronous reset in the middle of a divide.
        Div = 1'b1;
        Unsigned = 1'b1;
        op1 = 32'd100;
        op2 = 32'd7;
        @(negedge clk);
        Div = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRst_hi", hi, 32'h0);
        checkOutput("asyncRst_lo", lo, 32'h0000000F & 32'h0);
        checkOutput("asyncRst_busy", {31'd0, busy}, 32'd0);
        checkOutput("asyncRst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO.
- Sits beside the execute-stage ALU and receives the same op1/op2 operands and decode strobes.
- Supplies HI/LO read data to the ALU output mux.
- Replaces the single-cycle 64-bit multiply and divide with a 32-iteration shift/add (multiply) and restoring-subtract (divide) datapath.
- Raises a stall to the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH. Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op1  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO source
- op2  input  WIDTH  rt operand: multiplier / divisor
- Mul  input  1  start multiply
- Div  input  1  start divide
- Unsigned  input  1  1 = MULTU/DIVU, 0 = signed
- WriteHi  input  1  MTHI: hi <= op1
- WriteLo  input  1  MTLO: lo <= op1
- ReadHi  input  1  MFHI request (used only for stall)
- ReadLo  input  1  MFLO request (used only for stall)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO are updated by an operation
- stall  output  1  combinational: busy & (ReadHi | ReadLo | Mul | Div | WriteHi | WriteLo)

Behaviour:
- Reset (asynchronous, any time, including mid-operation): hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0. Partial results are discarded.
- States:
  - IDLE: waiting for a start.
  - CALC: 32 iterations.
  - FIN: sign fix-up and HI/LO write.
- IDLE, start condition:
  - Mul=1 or Div=1 at edge E0 latches the operands and the operation type, then moves to CALC.
  - Mul has priority if both are high.
- Signed operations:
  - Magnitudes are latched at E0.
  - Latched result signs: product sign = op1[31]^op2[31]; quotient sign = op1[31]^op2[31]; remainder sign = op1[31].
  - -2^31 magnitude is handled as unsigned 0x80000000 with no overflow in the 33-bit datapath.
- CALC:
  - One iteration per edge, E1..E32, counter 0..31.
  - After iteration 31, move to FIN.
- FIN (edge E33):
  - Apply the two's-complement sign fix.
  - Write hi/lo, assert done for the following cycle, return to IDLE.
- busy is 1 from after E0 through E33 inclusive (33 cycles).
  - A new Mul/Div may be accepted at E34; back-to-back operation is allowed.
- Multiply results: {hi,lo} = full 64-bit product.
- Divide results: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: deterministic, same 33-cycle latency.
  - lo = 0xFFFFFFFF, hi = op1 (original, unsigned or signed).
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- MTHI/MTLO:
  - In IDLE: WriteHi/WriteLo update hi/lo at the next edge. Both may be asserted in the same cycle.
  - If either is coincident with an accepted Mul/Div: the start wins and the writes are dropped.
- While busy:
  - Mul, Div, WriteHi and WriteLo are ignored.
  - The pipeline must hold them via stall and re-present them after done.
  - hi/lo hold their previous values until E33; no intermediate values are visible.
- Operand and Unsigned changes after E0 have no effect on an operation in flight.
- done = 0 except for the single cycle after FIN.

Test Plan:
- Signed MULT 0xFFFFFFFE*0x00000003 at E0 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA after E33; done high one cycle; busy 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Immediately followed at E34 by MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234 at E33. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy interactions:
  - Assert ReadLo, WriteHi=0xAAAA and Mul at cycle 5 of busy -> stall=1 those cycles; hi/lo unaffected by the write; the second Mul is not started.
  - WriteHi+WriteLo in IDLE with op1=0x5A5A -> hi=lo=0x5A5A next edge.
- Assert reset at E10 of a DIV -> hi=lo=0, busy=0, done=0 immediately (asynchronous); the next Mul after deassertion completes normally with correct result.
